fetch_control_unit: RTL and testbench



---
 rtl/rv_ctrl_pkg.sv | 68 ++++++
 rtl/imm_gen.sv | 24 ++
 rtl/fetch_control_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_control_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared RV64 control definitions: opcode/funct constants, FSM state encoding and the
// instruction classifier used by the fetch/control stage.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_SD      = 3'b011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;

  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  // ADDI x0,x0,0: a harmless instruction to hold in IR out of reset
  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    INS_ILLEGAL,
    INS_OP,
    INS_ADDI,
    INS_LD,
    INS_SD,
    INS_BRANCH
  } ins_e;

  function automatic ins_e decode_ins(input logic [6:0] opcode,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7);
    ins_e k;
    k = INS_ILLEGAL;
    case (opcode)
      OPC_LOAD:   if (f3 == F3_LD)   k = INS_LD;
      OPC_STORE:  if (f3 == F3_SD)   k = INS_SD;
      OPC_OP_IMM: if (f3 == F3_ADDI) k = INS_ADDI;
      OPC_OP: begin
        if (f3 == F3_ADD_SUB && (f7 == F7_ADD || f7 == F7_SUB)) k = INS_OP;
      end
      OPC_BRANCH: begin
        case (f3)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: k = INS_BRANCH;
          default: k = INS_ILLEGAL;
        endcase
      end
      default: k = INS_ILLEGAL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: sign-extends the I/S/B-type immediate to 64 bits.
// R-type and unrecognised formats produce zero.
module imm_gen
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [11:0] ir_hi_i,
  input  logic [4:0]  ir_rd_i,
  output logic [63:0] imm_o
);

  // ir_hi_i is IR[31:20]; ir_rd_i is IR[11:7]
  always_comb begin
    imm_o = '0;
    case (opcode_i)
      OPC_LOAD, OPC_OP_IMM: imm_o = {{52{ir_hi_i[11]}}, ir_hi_i};
      OPC_STORE:            imm_o = {{52{ir_hi_i[11]}}, ir_hi_i[11:5], ir_rd_i};
      OPC_BRANCH:           imm_o = {{51{ir_hi_i[11]}}, ir_hi_i[11], ir_rd_i[0],
                                     ir_hi_i[10:5], ir_rd_i[4:1], 1'b0};
      default:              imm_o = '0;
    endcase
  end

endmodule

// File: rtl/fetch_control_unit.sv
// Multi-cycle fetch/decode/control FSM for the RV64 datapath: 3 cycles per ALU/SD/branch and
// 4 per LD after fetch completes; stalls in FETCH with request/address held until imem_ready.
module fetch_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [63:0] immediate,
  output logic [4:0]  readRegister1,
  output logic [4:0]  readRegister2,
  output logic [4:0]  writeRegister,
  output logic [2:0]  funct3,
  output logic        writeEnable_DataMemory,
  output logic        writeEnable_Registers,
  output logic        muxSelect_SumVsReadData,
  output logic        muxSelect_ImmVsDataout2,
  output logic        SumOrSub,
  input  logic        selectedFlag,
  output logic [63:0] pc,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [63:0] pc_plus4;
  ins_e        ins_class;
  logic        rd_nz;

  assign ins_class     = decode_ins(ir_q[6:0], ir_q[14:12], ir_q[31:25]);
  assign rd_nz         = |ir_q[11:7];
  assign pc_plus4      = pc_q + 64'd4;

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign readRegister1 = ir_q[19:15];
  assign readRegister2 = ir_q[24:20];
  assign writeRegister = ir_q[11:7];
  assign funct3        = ir_q[14:12];

  imm_gen u_imm_gen (
    .opcode_i (ir_q[6:0]),
    .ir_hi_i  (ir_q[31:20]),
    .ir_rd_i  (ir_q[11:7]),
    .imm_o    (immediate)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSN;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = (ins_class == INS_ILLEGAL) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        case (ins_class)
          INS_LD: state_d = ST_MEM;
          INS_BRANCH: begin
            // flag arrives from the datapath this cycle, compare operands already selected
            pc_d    = selectedFlag ? (pc_q + immediate) : pc_plus4;
            state_d = ST_FETCH;
          end
          default: begin
            pc_d    = pc_plus4;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        pc_d    = pc_plus4;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req                = 1'b0;
    writeEnable_DataMemory  = 1'b0;
    writeEnable_Registers   = 1'b0;
    muxSelect_SumVsReadData = 1'b0;
    muxSelect_ImmVsDataout2 = 1'b0;
    SumOrSub                = 1'b0;
    halted                  = 1'b0;
    case (state_q)
      // gated by rst_n so the request drops the moment reset asserts
      ST_FETCH: imem_req = rst_n;
      ST_EXEC: begin
        case (ins_class)
          INS_OP: begin
            writeEnable_Registers = rd_nz;
            SumOrSub              = (ir_q[31:25] == F7_SUB);
          end
          INS_ADDI: begin
            writeEnable_Registers   = rd_nz;
            muxSelect_ImmVsDataout2 = 1'b1;
          end
          INS_SD: begin
            muxSelect_ImmVsDataout2 = 1'b1;
            writeEnable_DataMemory  = 1'b1;
          end
          INS_LD:     muxSelect_ImmVsDataout2 = 1'b1;
          INS_BRANCH: SumOrSub = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        muxSelect_ImmVsDataout2 = 1'b1;
        muxSelect_SumVsReadData = 1'b1;
        writeEnable_Registers   = rd_nz;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_control_unit.sv
// Randomised bench for fetch_control_unit: an instruction-level model predicts every cycle's
// outputs from each accepted fetch, with literal checks pinning the directed program.
module tb_fetch_control_unit;

  logic        clk, rst_n;
  logic        imem_req, imem_ready, selectedFlag;
  logic [63:0] imem_addr, immediate, pc;
  logic [31:0] imem_rdata;
  logic [4:0]  readRegister1, readRegister2, writeRegister;
  logic [2:0]  funct3;
  logic        writeEnable_DataMemory, writeEnable_Registers;
  logic        muxSelect_SumVsReadData, muxSelect_ImmVsDataout2, SumOrSub, halted;

  fetch_control_unit #(.RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .immediate(immediate),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .writeRegister(writeRegister), .funct3(funct3),
    .writeEnable_DataMemory(writeEnable_DataMemory),
    .writeEnable_Registers(writeEnable_Registers),
    .muxSelect_SumVsReadData(muxSelect_SumVsReadData),
    .muxSelect_ImmVsDataout2(muxSelect_ImmVsDataout2),
    .SumOrSub(SumOrSub), .selectedFlag(selectedFlag),
    .pc(pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [63:0] addr;
    logic [31:0] ins;
    logic        we_rf, we_dm, sel_rd, sel_imm, sub, hlt, chk, br_exec;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          br_cnt   = 0;
  logic        model_on = 1'b0;
  logic        pre_ready = 1'b1;
  logic        directed = 1'b1;
  logic [1:0]  want_ill = 2'd0;
  exp_t        q[$];
  exp_t        e_cur;
  logic [63:0] m_pc = 64'h0;
  logic        m_halt = 1'b0;
  logic        have_ins = 1'b0;
  logic        cur_flag = 1'b0;
  logic [31:0] cur_ins = 32'h13;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic legal(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    return (opc == 7'h03 && f3 == 3'd3) || (opc == 7'h23 && f3 == 3'd3) ||
           (opc == 7'h13 && f3 == 3'd0) ||
           (opc == 7'h33 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) ||
           (opc == 7'h63 && f3 != 3'd2 && f3 != 3'd3);
  endfunction

  // immediate as a signed integer value built from its field weights
  function automatic logic [63:0] model_imm(input logic [31:0] w);
    longint x;
    x = 0;
    case (w[6:0])
      7'h03, 7'h13: x = longint'(w[31:20]);
      7'h23:        x = longint'(w[31:25]) * 32 + longint'(w[11:7]);
      7'h63:        x = longint'(w[11:8]) * 2 + longint'(w[30:25]) * 32 + longint'(w[7]) * 2048;
      default:      x = 0;
    endcase
    if (w[6:0] != 7'h33 && w[31]) x = x - 4096;
    return 64'(x);
  endfunction

  function automatic logic [31:0] prog(input logic [63:0] a);
    case (a)
      64'h00:  return 32'h0050_0093;
      64'h04:  return 32'h0080_B103;
      64'h08:  return 32'h0020_B823;
      64'h0C:  return 32'h0000_01B3;
      64'h10:  return 32'h0020_8033;
      64'h20:  return 32'hFE10_8CE3;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic [31:0] gen_legal();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      1: begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
      2: begin w[6:0] = 7'h03; w[14:12] = 3'd3; end
      3: begin w[6:0] = 7'h23; w[14:12] = 3'd3; end
      default: begin
        w[6:0] = 7'h63;
        case ($urandom_range(0, 5))
          0: w[14:12] = 3'd0;
          1: w[14:12] = 3'd1;
          2: w[14:12] = 3'd4;
          3: w[14:12] = 3'd5;
          4: w[14:12] = 3'd6;
          default: w[14:12] = 3'd7;
        endcase
      end
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  function automatic logic [31:0] gen_illegal(input logic [1:0] kind);
    logic [31:0] w;
    w = $urandom;
    if (kind == 2'd2) return 32'hFFFF_FFFF;
    case ($urandom_range(0, 3))
      0: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(2, 3)); end
      1: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h01; end
      2: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
      default: for (int t = 0; t < 64 && legal(w); t++) w = $urandom;
    endcase
    if (legal(w)) w = 32'hFFFF_FFFF;
    return w;
  endfunction

  // queue the expected post-fetch cycles of one instruction and advance the model PC
  task automatic accept(input logic [31:0] ins);
    exp_t d, x, m;
    logic [6:0]  opc;
    logic [63:0] nxt;
    opc = ins[6:0];
    d = '0; d.addr = m_pc; d.ins = ins; d.chk = legal(ins);
    q.push_back(d);
    if (!legal(ins)) begin
      m_halt = 1'b1;
      return;
    end
    x = d; m = d;
    nxt = m_pc + 64'd4;
    if (opc == 7'h63) begin
      cur_flag = directed ? (br_cnt == 0) : 1'($urandom_range(0, 1));
      br_cnt++;
      x.sub = 1'b1; x.br_exec = 1'b1;
      if (cur_flag) nxt = m_pc + model_imm(ins);
    end else begin
      x.sel_imm = (opc != 7'h33);
      if (opc == 7'h33 || opc == 7'h13) begin
        x.we_rf = (ins[11:7] != 5'd0);
        x.sub   = (opc == 7'h33) && ins[30];
      end
      x.we_dm = (opc == 7'h23);
    end
    q.push_back(x);
    if (opc == 7'h03) begin
      m.sel_imm = 1'b1; m.sel_rd = 1'b1; m.we_rf = (ins[11:7] != 5'd0);
      q.push_back(m);
    end
    m_pc = nxt;
  endtask

  task automatic check_cycle(input exp_t e);
    chk("imem_req", imem_req, e.req);
    chk("imem_addr", imem_addr, e.addr);
    chk("pc", pc, e.addr);
    chk("we_regs", writeEnable_Registers, e.we_rf);
    chk("we_dmem", writeEnable_DataMemory, e.we_dm);
    chk("sel_sum_vs_rd", muxSelect_SumVsReadData, e.sel_rd);
    chk("sel_imm_vs_rs2", muxSelect_ImmVsDataout2, e.sel_imm);
    chk("sum_or_sub", SumOrSub, e.sub);
    chk("halted", halted, e.hlt);
    if (e.chk) begin
      chk("rs1", readRegister1, e.ins[19:15]);
      chk("rs2", readRegister2, e.ins[24:20]);
      chk("rd", writeRegister, e.ins[11:7]);
      chk("funct3", funct3, e.ins[14:12]);
      chk("immediate", immediate, model_imm(e.ins));
    end
  endtask

  always @(negedge clk) begin
    if (!model_on) begin
      q.delete();
      m_pc = 64'h0; m_halt = 1'b0; have_ins = 1'b0; br_cnt = 0; cyc = 0;
      imem_ready = pre_ready; imem_rdata = 32'h13; selectedFlag = 1'b0;
    end else begin
      if (q.size() != 0) e_cur = q.pop_front();
      else begin
        e_cur = '0;
        e_cur.addr = m_pc;
        if (m_halt) e_cur.hlt = 1'b1;
        else e_cur.req = 1'b1;
      end
      check_cycle(e_cur);
      selectedFlag = e_cur.br_exec ? cur_flag : 1'($urandom_range(0, 1));
      if (e_cur.req) begin
        if (!have_ins) begin
          if (directed) cur_ins = prog(m_pc);
          else if (want_ill != 2'd0) cur_ins = gen_illegal(want_ill);
          else cur_ins = gen_legal();
          have_ins = 1'b1;
        end
        imem_ready = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
        imem_rdata = imem_ready ? cur_ins : $urandom;
        if (imem_ready) begin
          accept(cur_ins);
          have_ins = 1'b0;
        end
      end else begin
        imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
      cyc++;
    end
  end

  task automatic wait_cycle(input int n);
    while (cyc <= n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic run_halt(input logic [1:0] kind);
    int n;
    want_ill = kind;
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("halt_reached", halted, 1'b1);
    repeat (20) begin
      @(negedge clk);
      #2;
    end
    chk("halt_req_low_20cyc", imem_req, 1'b0);
    chk("halt_still_halted", halted, 1'b1);
  endtask

  task automatic restart();
    @(posedge clk);
    #2;
    rst_n = 1'b0; model_on = 1'b0; want_ill = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    model_on = 1'b1; rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_we_regs", writeEnable_Registers, 1'b0);
    chk("rst_sel_imm", muxSelect_ImmVsDataout2, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 64'h0);
    pre_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("req_held_stalled", imem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("req_drop_on_reset", imem_req, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    model_on = 1'b1; rst_n = 1'b1;

    wait_cycle(0);  chk("lit_fetch0_addr", imem_addr, 64'h0);
    wait_cycle(2);
    chk("lit_addi_we", writeEnable_Registers, 1'b1);
    chk("lit_addi_rd", writeRegister, 5'd1);
    chk("lit_addi_imm", immediate, 64'd5);
    chk("lit_addi_immsel", muxSelect_ImmVsDataout2, 1'b1);
    chk("lit_addi_sub", SumOrSub, 1'b0);
    wait_cycle(3);  chk("lit_after_addi_addr", imem_addr, 64'h4);
    wait_cycle(5);  chk("lit_ld_exec_we", writeEnable_Registers, 1'b0);
    wait_cycle(6);
    chk("lit_ld_mem_selrd", muxSelect_SumVsReadData, 1'b1);
    chk("lit_ld_mem_we", writeEnable_Registers, 1'b1);
    wait_cycle(7);  chk("lit_ld_latency_addr", imem_addr, 64'h8);
    wait_cycle(9);
    chk("lit_sd_wedm", writeEnable_DataMemory, 1'b1);
    chk("lit_sd_imm", immediate, 64'd16);
    chk("lit_sd_rs2", readRegister2, 5'd2);
    chk("lit_sd_we_regs", writeEnable_Registers, 1'b0);
    wait_cycle(12); chk("lit_add_x3_we", writeEnable_Registers, 1'b1);
    wait_cycle(15); chk("lit_add_x0_we", writeEnable_Registers, 1'b0);
    wait_cycle(27);
    chk("lit_beq_sub", SumOrSub, 1'b1);
    chk("lit_beq_f3", funct3, 3'd0);
    chk("lit_beq_immsel", muxSelect_ImmVsDataout2, 1'b0);
    wait_cycle(28); chk("lit_beq_taken_addr", imem_addr, 64'h18);
    wait_cycle(37); chk("lit_beq_not_taken_addr", imem_addr, 64'h24);
    directed = 1'b0;

    wait_cycle(37 + 1500);
    run_halt(2'd2);
    for (int ep = 0; ep < 3; ep++) begin
      restart();
      wait_cycle(1200);
      run_halt(2'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
